muldiv_ctrl: RTL and testbench
==============================

Name: muldiv_ctrl

Overview:
- Iterative multiply/divide sequencer and HI/LO register owner for the EX stage of the 5-stage pipeline.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX with forwarded operands.
- Runs a radix-2 shift-add or restoring-divide loop for WIDTH cycles while holding the pipeline via MdStall.
- Writes HI/LO on completion; MFHI/MFLO read HiData/LoData combinationally.

Parameters:
- WIDTH, 32, operand/HI/LO width; iteration count equals WIDTH.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- MdStart  in  1  EX stage holds a valid muldiv/MT op this cycle.
- MdOp  in  3  op code, MD_* encodings from the package.
- SrcA  in  WIDTH  forwarded rs value (dividend, multiplicand, MT source).
- SrcB  in  WIDTH  forwarded rt value (divisor, multiplier).
- Flush  in  1  kill the in-flight op.
- MdStall  out  1  freeze PC, IF/ID, ID/EX and EX operands.
- MdBusy  out  1  state != IDLE.
- HiData  out  WIDTH  current HI register.
- LoData  out  WIDTH  current LO register.

Behaviour:
- Reset (rstn=0, asynchronous): state=IDLE, HI=0, LO=0, counter=0, MdStall=0, MdBusy=0.
- MdOp encodings: MD_MULT=000, MD_MULTU=001, MD_DIV=010, MD_DIVU=011, MD_MTHI=100, MD_MTLO=101. Codes 110 and 111 are no-ops with no stall.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - MdStart with MTHI/MTLO: HI/LO := SrcA at the edge; no stall; stay IDLE.
  - MdStart with a mul/div op: latch operands; for signed ops latch magnitudes plus sign flags. Counter := WIDTH-1. Go to RUN. MdStall=1 combinationally in this cycle.
- RUN: one iteration per cycle; MdStall=1; after the counter reaches 0, go to DONE. Total RUN cycles = WIDTH.
- DONE: MdStall=0 and EX advances this cycle. HI/LO written at the closing edge; go to IDLE. MdStart is ignored in DONE (same instruction).
- Latency (WIDTH=32): MdStall high 33 consecutive cycles. HI/LO are valid from the cycle after DONE, so an MFHI immediately following reads the new value.
- Multiply result: {HI,LO} = 2*WIDTH-bit product. Signed ops negate the product when signA^signB.
- Divide results:
  - LO = quotient, HI = remainder.
  - Signed: quotient negated when signA^signB; remainder takes the sign of SrcA.
  - Divide by zero (any signedness): LO = all ones, HI = SrcA.
  - DIV of 0x80000000 by 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- Flush:
  - Priority over MdStart.
  - In RUN or the IDLE start cycle: abort, state := IDLE next cycle, HI/LO unchanged, MdStall drops in the cycle after Flush.
  - A flushed MTHI/MTLO does not write.
- Reset mid-operation: immediate IDLE; HI/LO cleared.

Optional Feature:
- Macro: MULDIV_EARLY_TERM_EN.
- Defined: a divide with SrcB==0, or a multiply with SrcA==0 or SrcB==0, skips RUN and goes IDLE -> DONE. MdStall is high 1 cycle; results are identical to the full-latency path.
- Undefined: every mul/div takes the full WIDTH+1 stall cycles.

Decomposition:
- Shared package muldiv_pkg holds:
  - MD_* op encodings;
  - FSM state typedef;
  - MD_WIDTH default.
- One natural sub-module: muldiv_iter_dp, the shift/add/subtract datapath with partial remainder and product registers, one step per enable.
- muldiv_ctrl keeps the FSM, counter, sign fix-up, stall and HI/LO.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; MdStall high exactly 33 cycles; MdBusy mirrors state.
- MULT 0xFFFFFFFD x 0x00000005 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1. Follow with MTLO 0x12345678 -> LO updated next cycle, no stall.
- DIV 0xFFFFFFF9 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/2 -> LO=3, HI=1. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 5/0 -> LO=0xFFFFFFFF, HI=5. Stall 33 cycles without MULDIV_EARLY_TERM_EN, 1 cycle with it.
- MULT 3x4 with Flush asserted on RUN cycle 10 -> MdStall low the next cycle, HI/LO keep prior values. Flush and MdStart together -> no start, no stall.
- rstn pulsed low mid-DIV -> HI=LO=0 and MdStall=0 immediately; a new DIVU 9/3 after release -> LO=3, HI=0.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM state type and default operand width.
package muldiv_pkg;

  localparam int unsigned MD_WIDTH = 32;

  typedef enum logic [2:0] {
    MD_MULT  = 3'b000,
    MD_MULTU = 3'b001,
    MD_DIV   = 3'b010,
    MD_DIVU  = 3'b011,
    MD_MTHI  = 3'b100,
    MD_MTLO  = 3'b101
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } md_state_e;

  // Codes 000..011 are the iterative ops
  function automatic logic md_is_muldiv(logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

  // Codes 100/101 move SrcA into HI/LO; 110/111 are no-ops
  function automatic logic md_is_mt(logic [2:0] op);
    return (op[2:1] == 2'b10);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// EX-stage <-> multiply/divide unit signal bundle.
interface muldiv_if #(
  parameter int unsigned WIDTH = muldiv_pkg::MD_WIDTH
);
  logic             MdStart;
  logic [2:0]       MdOp;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic             Flush;
  logic             MdStall;
  logic             MdBusy;
  logic [WIDTH-1:0] HiData;
  logic [WIDTH-1:0] LoData;

  modport master (
    output MdStart, MdOp, SrcA, SrcB, Flush,
    input  MdStall, MdBusy, HiData, LoData
  );

  modport slave (
    input  MdStart, MdOp, SrcA, SrcB, Flush,
    output MdStall, MdBusy, HiData, LoData
  );
endinterface

// File: rtl/muldiv_iter_dp.sv
// Radix-2 shift-add multiply / restoring divide datapath; one step per enable.
// Operands are unsigned magnitudes; sign handling lives in the controller.
module muldiv_iter_dp #(
  parameter int unsigned WIDTH = muldiv_pkg::MD_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] quo
);

  logic [WIDTH-1:0] acc_q, quo_q, b_q;
  logic             div_q;
  logic [WIDTH-1:0] acc_n, quo_n;
  logic [WIDTH:0]   sum, sh;
  logic             ge;

  // Multiply: {acc,quo} shifts right, quo starts as multiplier.
  // Divide: {acc,quo} shifts left, quo starts as dividend and collects quotient bits.
  always_comb begin
    sum   = {1'b0, acc_q} + (quo_q[0] ? {1'b0, b_q} : '0);
    sh    = {acc_q, quo_q[WIDTH-1]};
    ge    = (sh >= {1'b0, b_q});
    acc_n = sum[WIDTH:1];
    quo_n = {sum[0], quo_q[WIDTH-1:1]};
    if (div_q) begin
      acc_n = ge ? WIDTH'(sh - {1'b0, b_q}) : WIDTH'(sh);
      quo_n = {quo_q[WIDTH-2:0], ge};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      quo_q <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
    end else if (load) begin
      acc_q <= '0;
      div_q <= is_div;
      quo_q <= is_div ? op_a : op_b;
      b_q   <= is_div ? op_b : op_a;
    end else if (step) begin
      acc_q <= acc_n;
      quo_q <= quo_n;
    end
  end

  assign acc = acc_q;
  assign quo = quo_q;

endmodule

// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer and HI/LO owner for EX; stalls the pipe while iterating.
// Optional MULDIV_EARLY_TERM_EN: zero-operand mul/div skips the iteration loop.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH
) (
  input logic     clk,
  input logic     rstn,
  muldiv_if.slave md
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  md_state_e state_q, state_n;

  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic [WIDTH-1:0]   a_raw_q;
  logic               div_q, sa_q, sb_q, zero_q;

  logic               start, op_md, op_mt, op_div, op_signed, early, zero_in;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               stall, dp_load, dp_step, hi_we, lo_we, res_we;
  logic [WIDTH-1:0]   dp_acc, dp_quo;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   res_hi, res_lo;

  // Op decode; Flush masks the start
  assign start     = md.MdStart && !md.Flush;
  assign op_md     = md_is_muldiv(md.MdOp);
  assign op_mt     = md_is_mt(md.MdOp);
  assign op_div    = md.MdOp[1];
  assign op_signed = ~md.MdOp[0];
  assign mag_a     = (op_signed && md.SrcA[WIDTH-1]) ? -md.SrcA : md.SrcA;
  assign mag_b     = (op_signed && md.SrcB[WIDTH-1]) ? -md.SrcB : md.SrcB;
  assign zero_in   = op_div ? (md.SrcB == '0) : ((md.SrcA == '0) || (md.SrcB == '0));

`ifdef MULDIV_EARLY_TERM_EN
  assign early = zero_in;
`else
  assign early = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      ST_IDLE: if (start && op_md) state_n = early ? ST_DONE : ST_RUN;
      ST_RUN: begin
        if (md.Flush)          state_n = ST_IDLE;
        else if (cnt_q == '0)  state_n = ST_DONE;
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    stall   = 1'b0;
    dp_load = 1'b0;
    dp_step = 1'b0;
    hi_we   = 1'b0;
    lo_we   = 1'b0;
    res_we  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start && op_md) begin
          stall   = 1'b1;
          dp_load = 1'b1;
        end
        if (start && op_mt) begin
          hi_we = ~md.MdOp[0];
          lo_we = md.MdOp[0];
        end
      end
      ST_RUN: begin
        stall   = 1'b1;
        dp_step = !md.Flush;
      end
      ST_DONE: res_we = !md.Flush;
      default: ;
    endcase
  end

  // Per-op context captured at start for the final fix-up
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_q   <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      zero_q  <= 1'b0;
      a_raw_q <= '0;
    end else if (dp_load) begin
      div_q   <= op_div;
      sa_q    <= op_signed && md.SrcA[WIDTH-1];
      sb_q    <= op_signed && md.SrcB[WIDTH-1];
      zero_q  <= zero_in;
      a_raw_q <= md.SrcA;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                          cnt_q <= '0;
    else if (dp_load)                   cnt_q <= CNT_LAST;
    else if (dp_step && cnt_q != '0)    cnt_q <= cnt_q - 1'b1;
  end

  muldiv_iter_dp #(.WIDTH(WIDTH)) u_dp (
    .clk    (clk),
    .rst_n  (rstn),
    .load   (dp_load),
    .step   (dp_step),
    .is_div (op_div),
    .op_a   (mag_a),
    .op_b   (mag_b),
    .acc    (dp_acc),
    .quo    (dp_quo)
  );

  // Sign fix-up and zero-operand overrides (also cover the early-exit path)
  always_comb begin
    prod   = {dp_acc, dp_quo};
    res_hi = dp_acc;
    res_lo = dp_quo;
    if (div_q) begin
      if (zero_q) begin
        res_hi = a_raw_q;
        res_lo = '1;
      end else begin
        res_lo = (sa_q ^ sb_q) ? -dp_quo : dp_quo;
        res_hi = sa_q ? -dp_acc : dp_acc;
      end
    end else if (zero_q) begin
      res_hi = '0;
      res_lo = '0;
    end else if (sa_q ^ sb_q) begin
      {res_hi, res_lo} = -prod;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (hi_we) hi_q <= md.SrcA;
      if (lo_we) lo_q <= md.SrcA;
      if (res_we) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end
    end
  end

  assign md.MdStall = stall;
  assign md.MdBusy  = (state_q != ST_IDLE);
  assign md.HiData  = hi_q;
  assign md.LoData  = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: driver queues expected HI/LO and stall
// counts; a negedge monitor checks them when an op retires, flushes or resets.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  muldiv_if #(.WIDTH(32)) bus ();

  muldiv_ctrl #(.WIDTH(32)) dut (
    .clk  (clk),
    .rstn (rstn),
    .md   (bus.slave)
  );

  typedef struct {
    bit          is_reset;
    string       name;
    int          stall_n;
    bit          busy_evt;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        sb[$];
  int          compared   = 0;
  int          mismatched = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  localparam int FULL_STALL = 33;
`ifdef MULDIV_EARLY_TERM_EN
  localparam int ZERO_STALL = 1;
`else
  localparam int ZERO_STALL = 33;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic expect_op(input string name, input int stall_n, input bit busy_evt,
                           input logic [31:0] hi, input logic [31:0] lo);
    exp_t e;
    m_hi = hi;
    m_lo = lo;
    e.is_reset = 1'b0;
    e.name     = name;
    e.stall_n  = stall_n;
    e.busy_evt = busy_evt;
    e.hi       = hi;
    e.lo       = lo;
    sb.push_back(e);
  endtask

  task automatic expect_reset(input string name);
    exp_t e;
    m_hi = '0;
    m_lo = '0;
    e.is_reset = 1'b1;
    e.name     = name;
    e.stall_n  = 0;
    e.busy_evt = 1'b0;
    e.hi       = '0;
    e.lo       = '0;
    sb.push_back(e);
  endtask

  // Hold the op in EX until the unit stops stalling, as the pipeline would
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    @(posedge clk);
    #1;
    bus.MdStart = 1'b1;
    bus.MdOp    = op;
    bus.SrcA    = a;
    bus.SrcB    = b;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.MdStall && n < 200);
    compared++;
    if (bus.MdStall) begin
      mismatched++;
      $display("FAIL issue_timeout: op %0d still stalled after %0d cycles, expected release", op, n);
    end
    @(posedge clk);
    #1;
    bus.MdStart = 1'b0;
  endtask

  // Monitor
  initial begin
    int   run;
    bit   pend;
    bit   in_rst;
    exp_t e;
    run = 0;
    pend = 1'b0;
    in_rst = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        if (!in_rst) begin
          in_rst = 1'b1;
          if (sb.size() == 0 || !sb[0].is_reset) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_reset: got reset, expected no reset");
          end else begin
            e = sb.pop_front();
            chk({e.name, "_hi"},    bus.HiData, 32'h0);
            chk({e.name, "_lo"},    bus.LoData, 32'h0);
            chk({e.name, "_stall"}, {31'b0, bus.MdStall}, 32'h0);
            chk({e.name, "_busy"},  {31'b0, bus.MdBusy},  32'h0);
          end
        end
        pend = 1'b0;
        run  = 0;
      end else begin
        in_rst = 1'b0;
        if (pend) begin
          e = sb.pop_front();
          chk({e.name, "_hi"},         bus.HiData, e.hi);
          chk({e.name, "_lo"},         bus.LoData, e.lo);
          chk({e.name, "_stall_after"}, {31'b0, bus.MdStall}, 32'h0);
          chk({e.name, "_busy_after"},  {31'b0, bus.MdBusy},  32'h0);
          pend = 1'b0;
        end
        if (bus.MdStall) run++;
        if ((bus.MdStart && !bus.MdStall) || bus.Flush) begin
          if (sb.size() == 0 || sb[0].is_reset) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_event: got retire/flush, expected none");
          end else begin
            chk({sb[0].name, "_stall_cycles"}, 32'(run), 32'(sb[0].stall_n));
            chk({sb[0].name, "_busy"}, {31'b0, bus.MdBusy}, {31'b0, sb[0].busy_evt});
            pend = 1'b1;
          end
          run = 0;
        end else if (!bus.MdStall) begin
          run = 0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Driver
  initial begin
    rstn        = 1'b0;
    bus.MdStart = 1'b0;
    bus.MdOp    = 3'b000;
    bus.SrcA    = '0;
    bus.SrcB    = '0;
    bus.Flush   = 1'b0;
    expect_reset("por");
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    expect_op("multu_max", FULL_STALL, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001);
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    expect_op("mult_neg", FULL_STALL, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    issue(MD_MULT, 32'hFFFF_FFFD, 32'h0000_0005);

    expect_op("mtlo", 0, 1'b0, m_hi, 32'h1234_5678);
    issue(MD_MTLO, 32'h1234_5678, 32'h0);

    expect_op("mthi", 0, 1'b0, 32'hCAFE_F00D, m_lo);
    issue(MD_MTHI, 32'hCAFE_F00D, 32'h0);

    expect_op("div_neg7_2", FULL_STALL, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    issue(MD_DIV, 32'hFFFF_FFF9, 32'h0000_0002);

    expect_op("divu_7_2", FULL_STALL, 1'b1, 32'h0000_0001, 32'h0000_0003);
    issue(MD_DIVU, 32'h7, 32'h2);

    expect_op("div_ovf", FULL_STALL, 1'b1, 32'h0000_0000, 32'h8000_0000);
    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);

    expect_op("divu_5_0", ZERO_STALL, 1'b1, 32'h0000_0005, 32'hFFFF_FFFF);
    issue(MD_DIVU, 32'h5, 32'h0);

    expect_op("div_neg7_0", ZERO_STALL, 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    issue(MD_DIV, 32'hFFFF_FFF9, 32'h0);

    expect_op("div_7_neg2", FULL_STALL, 1'b1, 32'h0000_0001, 32'hFFFF_FFFD);
    issue(MD_DIV, 32'h7, 32'hFFFF_FFFE);

    // Flush on the tenth RUN cycle: 1 start + 10 RUN stall cycles seen
    expect_op("mult_flush_run", 11, 1'b1, m_hi, m_lo);
    @(posedge clk);
    #1;
    bus.MdStart = 1'b1;
    bus.MdOp    = MD_MULT;
    bus.SrcA    = 32'd3;
    bus.SrcB    = 32'd4;
    repeat (10) @(posedge clk);
    #1 bus.Flush = 1'b1;
    @(posedge clk);
    #1;
    bus.Flush   = 1'b0;
    bus.MdStart = 1'b0;

    expect_op("flush_with_start", 0, 1'b0, m_hi, m_lo);
    @(posedge clk);
    #1;
    bus.MdStart = 1'b1;
    bus.MdOp    = MD_MULT;
    bus.Flush   = 1'b1;
    @(posedge clk);
    #1;
    bus.MdStart = 1'b0;
    bus.Flush   = 1'b0;

    expect_op("flushed_mthi", 0, 1'b0, m_hi, m_lo);
    @(posedge clk);
    #1;
    bus.MdStart = 1'b1;
    bus.MdOp    = MD_MTHI;
    bus.SrcA    = 32'hDEAD_BEEF;
    bus.Flush   = 1'b1;
    @(posedge clk);
    #1;
    bus.MdStart = 1'b0;
    bus.Flush   = 1'b0;

    expect_op("noop_110", 0, 1'b0, m_hi, m_lo);
    issue(3'b110, 32'h1111_1111, 32'h2222_2222);

    expect_op("mult_3_4", FULL_STALL, 1'b1, 32'h0, 32'd12);
    issue(MD_MULT, 32'd3, 32'd4);

    // Reset in the middle of a divide
    @(posedge clk);
    #1;
    bus.MdStart = 1'b1;
    bus.MdOp    = MD_DIV;
    bus.SrcA    = 32'd100;
    bus.SrcB    = 32'd7;
    repeat (5) @(posedge clk);
    #1;
    expect_reset("mid_div_reset");
    rstn        = 1'b0;
    bus.MdStart = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    expect_op("divu_9_3", FULL_STALL, 1'b1, 32'h0, 32'd3);
    issue(MD_DIVU, 32'd9, 32'd3);

    repeat (5) @(posedge clk);
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
